// File: rtl/mac_pkg.sv
// Shared types, widths and helpers for the matrix-vector MAC controller.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_X,
        ST_LOAD_W,
        ST_COMPUTE,
        ST_WRITE,
        ST_DONE
    } state_e;

    localparam int ACC_WIDTH  = 48;
    localparam int PROD_WIDTH = 32;

    // Word index of y[0]: directly after x and the whole weight matrix.
    function automatic int res_base(input int vector_size, input int num_rows);
        return vector_size * (num_rows + 1);
    endfunction

    function automatic logic [31:0] sat32(input logic [ACC_WIDTH-1:0] acc);
        if ((&acc[ACC_WIDTH-1:31]) || !(|acc[ACC_WIDTH-1:31]))
            return acc[31:0];
        return acc[ACC_WIDTH-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: local weight RAM, registered read, multiply register, 48-bit accumulator.
// MAC_SAT_EN selects a saturated 32-bit result instead of the wrapped low word.
module mac_lane
    import mac_pkg::*;
#(
    parameter int L_RAM_SIZE = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [L_RAM_SIZE-1:0] waddr_i,
    input  logic [15:0]           wdata_i,
    input  logic                  rd_en_i,
    input  logic [L_RAM_SIZE-1:0] raddr_i,
    input  logic [15:0]           x_i,
    input  logic                  mul_en_i,
    input  logic                  clr_i,
    output logic [31:0]           res_o
);

    logic [15:0]                  wram [2**L_RAM_SIZE];
    logic [15:0]                  w_q;
    logic signed [31:0]           x_ext, w_ext;
    logic signed [PROD_WIDTH-1:0] prod_q;
    logic                         prod_vld_q;
    logic [ACC_WIDTH-1:0]         acc_q;

    assign x_ext = {{16{x_i[15]}}, x_i};
    assign w_ext = {{16{w_q[15]}}, w_q};

    // RAM and read register carry no reset so the array maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (we_i)
            wram[waddr_i] <= wdata_i;
        if (rd_en_i)
            w_q <= wram[raddr_i];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            prod_vld_q <= mul_en_i;
            if (mul_en_i)
                prod_q <= x_ext * w_ext;
            if (clr_i)
                acc_q <= '0;
            else if (prod_vld_q)
                acc_q <= acc_q + {{(ACC_WIDTH-PROD_WIDTH){prod_q[PROD_WIDTH-1]}}, prod_q};
        end
    end

`ifdef MAC_SAT_EN
    assign res_o = sat32(acc_q);
`else
    assign res_o = acc_q[31:0];
`endif

endmodule

// File: rtl/mac_array_con.sv
// Matrix-vector MAC controller: loads x and NUM_PE weight rows per group from BRAM,
// runs the lanes in lockstep and writes y back. Lane result format set by MAC_SAT_EN.
module mac_array_con
    import mac_pkg::*;
#(
    parameter int VECTOR_SIZE = 64,
    parameter int L_RAM_SIZE  = 6,
    parameter int NUM_PE      = 4,
    parameter int NUM_ROWS    = 8,
    parameter int RD_LATENCY  = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        done,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        BRAM_CLK,
    input  logic [31:0] BRAM_RDDATA
);

    localparam int NG       = NUM_ROWS / NUM_PE;
    localparam int LX_LEN   = VECTOR_SIZE + RD_LATENCY;
    localparam int LW_LEN   = NUM_PE * VECTOR_SIZE + RD_LATENCY;
    localparam int CP_LEN   = VECTOR_SIZE + 3;
    localparam int PL_MAX   = (LW_LEN > CP_LEN) ? LW_LEN : CP_LEN;
    localparam int CW       = $clog2(PL_MAX + 1);
    localparam int LW       = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int GW       = (NG > 1) ? $clog2(NG) : 1;
    localparam int RES_BASE = res_base(VECTOR_SIZE, NUM_ROWS);

    state_e                       state_q, state_d;
    logic [CW-1:0]                cnt_q, cnt_d, plen_m1;
    logic [GW-1:0]                grp_q, grp_d;
    logic                         done_q, done_d;
    logic                         busy, phase_last, rd_issue, cap_en, comp_rd, rd_vld_q;
    logic [RD_LATENCY:1]          vld_pipe_q;
    logic [L_RAM_SIZE-1:0]        cap_k_q;
    logic [LW-1:0]                cap_lane_q;
    logic [15:0]                  xram [2**L_RAM_SIZE];
    logic [15:0]                  x_q;
    logic [NUM_PE-1:0][31:0]      lane_res;
    logic [31:0]                  word;
    logic                         unused_hi;

    assign unused_hi = ^BRAM_RDDATA[31:16];

    assign busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign phase_last = busy && (cnt_q == plen_m1);
    assign rd_issue   = ((state_q == ST_LOAD_X) && (cnt_q < CW'(VECTOR_SIZE))) ||
                        ((state_q == ST_LOAD_W) && (cnt_q < CW'(NUM_PE * VECTOR_SIZE)));
    assign cap_en     = vld_pipe_q[RD_LATENCY];
    assign comp_rd    = (state_q == ST_COMPUTE) && (cnt_q < CW'(VECTOR_SIZE));

    always_comb begin
        plen_m1 = '0;
        case (state_q)
            ST_LOAD_X:  plen_m1 = CW'(LX_LEN - 1);
            ST_LOAD_W:  plen_m1 = CW'(LW_LEN - 1);
            ST_COMPUTE: plen_m1 = CW'(CP_LEN - 1);
            ST_WRITE:   plen_m1 = CW'(NUM_PE - 1);
            default:    plen_m1 = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        grp_d   = grp_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) state_d = ST_LOAD_X;
            end
            ST_DONE: begin
                cnt_d  = '0;
                done_d = !start;
                if (start) state_d = ST_LOAD_X;
            end
            ST_LOAD_X:  if (phase_last) begin state_d = ST_LOAD_W;  cnt_d = '0; end
            ST_LOAD_W:  if (phase_last) begin state_d = ST_COMPUTE; cnt_d = '0; end
            ST_COMPUTE: if (phase_last) begin state_d = ST_WRITE;   cnt_d = '0; end
            ST_WRITE: begin
                if (phase_last) begin
                    cnt_d = '0;
                    if (grp_q == GW'(NG - 1)) begin
                        state_d = ST_DONE;
                        grp_d   = '0;
                    end else begin
                        state_d = ST_LOAD_W;
                        grp_d   = grp_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // done lags the DONE state by one cycle so it rises one cycle after entry.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grp_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grp_q   <= grp_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            vld_pipe_q <= '0;
            cap_k_q    <= '0;
            cap_lane_q <= '0;
            rd_vld_q   <= 1'b0;
        end else begin
            vld_pipe_q[1] <= rd_issue;
            for (int i = 2; i <= RD_LATENCY; i++)
                vld_pipe_q[i] <= vld_pipe_q[i-1];
            if (phase_last) begin
                cap_k_q    <= '0;
                cap_lane_q <= '0;
            end else if (cap_en) begin
                if (cap_k_q == L_RAM_SIZE'(VECTOR_SIZE - 1)) begin
                    cap_k_q    <= '0;
                    cap_lane_q <= cap_lane_q + LW'(1);
                end else begin
                    cap_k_q <= cap_k_q + L_RAM_SIZE'(1);
                end
            end
            rd_vld_q <= comp_rd;
        end
    end

    always_ff @(posedge aclk) begin
        if (cap_en && (state_q == ST_LOAD_X))
            xram[cap_k_q] <= BRAM_RDDATA[15:0];
        if (comp_rd)
            x_q <= xram[L_RAM_SIZE'(cnt_q)];
    end

    for (genvar j = 0; j < NUM_PE; j++) begin : g_lane
        mac_lane #(.L_RAM_SIZE(L_RAM_SIZE)) u_lane (
            .clk_i    (aclk),
            .rst_ni   (aresetn),
            .we_i     (cap_en && (state_q == ST_LOAD_W) && (cap_lane_q == LW'(j))),
            .waddr_i  (cap_k_q),
            .wdata_i  (BRAM_RDDATA[15:0]),
            .rd_en_i  (comp_rd),
            .raddr_i  (L_RAM_SIZE'(cnt_q)),
            .x_i      (x_q),
            .mul_en_i (rd_vld_q),
            .clr_i    ((state_q == ST_COMPUTE) && (cnt_q == '0)),
            .res_o    (lane_res[j])
        );
    end

    always_comb begin
        word = '0;
        case (state_q)
            ST_LOAD_X: if (rd_issue) word = 32'(cnt_q);
            ST_LOAD_W: if (rd_issue)
                word = 32'(VECTOR_SIZE) + 32'(grp_q) * 32'(NUM_PE * VECTOR_SIZE) + 32'(cnt_q);
            ST_WRITE:  word = 32'(RES_BASE) + 32'(grp_q) * 32'(NUM_PE) + 32'(cnt_q);
            default:   word = '0;
        endcase
    end

    assign BRAM_ADDR   = word << 2;
    assign BRAM_WE     = (state_q == ST_WRITE) ? 4'hF : 4'h0;
    assign BRAM_WRDATA = (state_q == ST_WRITE) ? lane_res[LW'(cnt_q)] : 32'h0;
    assign BRAM_CLK    = aclk;
    assign done        = done_q;

endmodule

// File: tb/tb_mac_array_con.sv
// Self-checking bench for mac_array_con: table vectors, hand sequences and random data vs a dot-product model.
module tb_mac_array_con;

    localparam int VS = 64;
    localparam int NR = 8;
    localparam int NP = 4;
    localparam int RB = VS * (NR + 1);
    localparam int DONE_LAT = 725;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        done, BRAM_CLK;
    logic [31:0] BRAM_ADDR, BRAM_WRDATA, BRAM_RDDATA;
    logic [3:0]  BRAM_WE;

    always #5 aclk = ~aclk;

    mac_array_con #(
        .VECTOR_SIZE(VS), .L_RAM_SIZE(6), .NUM_PE(NP), .NUM_ROWS(NR), .RD_LATENCY(2)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .done(done),
        .BRAM_ADDR(BRAM_ADDR), .BRAM_WRDATA(BRAM_WRDATA), .BRAM_WE(BRAM_WE),
        .BRAM_CLK(BRAM_CLK), .BRAM_RDDATA(BRAM_RDDATA)
    );

    // BRAM model: two-cycle read latency, writes logged rather than stored
    logic [31:0] mem [1024];
    logic [31:0] rd_p1, rd_p2;
    logic [31:0] wq_a[$];
    logic [31:0] wq_d[$];
    assign BRAM_RDDATA = rd_p2;

    always @(posedge aclk) begin
        rd_p1 <= mem[BRAM_ADDR[11:2]];
        rd_p2 <= rd_p1;
        if (BRAM_WE != 4'h0) begin
            wq_a.push_back(BRAM_ADDR >> 2);
            wq_d.push_back(BRAM_WRDATA);
        end
    end

    int errs = 0;
    int checks = 0;

    logic [31:0] xw [VS];
    logic [31:0] ww [NR][VS];
    logic [31:0] exp_y [NR];

    typedef struct {
        logic [31:0] xv;
        logic [31:0] wv;
        logic [31:0] y;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load_mem();
        for (int k = 0; k < VS; k++) mem[k] = xw[k];
        for (int r = 0; r < NR; r++)
            for (int k = 0; k < VS; k++) mem[VS + r*VS + k] = ww[r][k];
    endtask

    function automatic logic [31:0] model(input int r);
        longint acc = 0;
        logic signed [15:0] a, b;
        for (int k = 0; k < VS; k++) begin
            a = xw[k][15:0];
            b = ww[r][k][15:0];
            acc += longint'(a) * longint'(b);
        end
`ifdef MAC_SAT_EN
        if (acc > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (acc < -64'sd2147483648) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    // One full run; extra start pulses are sampled at the end of cycles p1/p2 (0 = none).
    task automatic run_check(input string nm, input int p1, input int p2);
        int base, lat, nw;
        base = wq_a.size();
        lat = 0;
        @(negedge aclk); start = 1'b1;
        @(posedge aclk); #1; start = 1'b0;
        chk({nm, " done_clr"}, {31'b0, done}, 32'd0);
        chk({nm, " addr0"}, BRAM_ADDR, 32'd0);
        for (int n = 1; n <= 2000; n++) begin
            @(posedge aclk); #1;
            start = (n == p1 || n == p2);
            if (done) begin
                lat = n;
                break;
            end
        end
        start = 1'b0;
        chk({nm, " done_lat"}, lat, DONE_LAT);
        nw = wq_a.size() - base;
        chk({nm, " nwrites"}, nw, NR);
        for (int j = 0; j < NR && j < nw; j++) begin
            chk($sformatf("%s addr%0d", nm, j), wq_a[base+j], RB + j);
            chk($sformatf("%s y%0d", nm, j), wq_d[base+j], exp_y[j]);
        end
    endtask

    initial begin
        int base;
        tbl[0] = '{32'h0000_0001, 32'h0000_0001, 32'd64};
        tbl[1] = '{32'h0000_FFFF, 32'h0000_8000, 32'h0020_0000};
        tbl[2] = '{32'hABCD_FFFF, 32'h1234_8000, 32'h0020_0000};
`ifdef MAC_SAT_EN
        tbl[3] = '{32'h0000_8000, 32'h0000_8000, 32'h7FFF_FFFF};
        tbl[4] = '{32'h0000_7FFF, 32'h0000_7FFF, 32'h7FFF_FFFF};
        tbl[5] = '{32'h0000_8000, 32'h0000_7FFF, 32'h8000_0000};
`else
        tbl[3] = '{32'h0000_8000, 32'h0000_8000, 32'h0000_0000};
        tbl[4] = '{32'h0000_7FFF, 32'h0000_7FFF, 32'hFFC0_0040};
        tbl[5] = '{32'h0000_8000, 32'h0000_7FFF, 32'h0020_0000};
`endif
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst done", {31'b0, done}, 32'd0);
        chk("rst addr", BRAM_ADDR, 32'd0);
        chk("rst wrdata", BRAM_WRDATA, 32'd0);
        chk("rst we", {28'b0, BRAM_WE}, 32'd0);
        @(negedge aclk); aresetn = 1'b1;

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < VS; k++) xw[k] = tbl[t].xv;
            for (int r = 0; r < NR; r++) begin
                for (int k = 0; k < VS; k++) ww[r][k] = tbl[t].wv;
                exp_y[r] = tbl[t].y;
            end
            load_mem();
            run_check($sformatf("tbl%0d", t), 0, 0);
        end

        // x[k]=k, row r filled with r, with starts during LOAD_W and COMPUTE that must be ignored
        for (int k = 0; k < VS; k++) xw[k] = k;
        for (int r = 0; r < NR; r++) begin
            for (int k = 0; k < VS; k++) ww[r][k] = r;
            exp_y[r] = 2016 * r;
        end
        load_mem();
        run_check("ramp", 100, 350);

        // reset held for one cycle in the middle of COMPUTE of group 0
        base = wq_a.size();
        @(negedge aclk); start = 1'b1;
        @(posedge aclk); #1; start = 1'b0;
        repeat (330) @(posedge aclk);
        #1; aresetn = 1'b0;
        @(posedge aclk); #1; aresetn = 1'b1;
        chk("midrst we", {28'b0, BRAM_WE}, 32'd0);
        chk("midrst done", {31'b0, done}, 32'd0);
        chk("midrst addr", BRAM_ADDR, 32'd0);
        repeat (800) @(posedge aclk);
        #1;
        chk("midrst nowrite", wq_a.size() - base, 32'd0);
        chk("midrst idle done", {31'b0, done}, 32'd0);

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < VS; k++) xw[k] = $urandom();
            for (int r = 0; r < NR; r++)
                for (int k = 0; k < VS; k++) ww[r][k] = $urandom();
            if (t == 1)
                for (int k = 0; k < VS; k++) xw[k] = {$urandom_range(65535), 16'h8000};
            for (int r = 0; r < NR; r++) exp_y[r] = model(r);
            load_mem();
            run_check($sformatf("rnd%0d", t), 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
